// File: rtl/tile_load_sequencer_pkg.sv
// Shared definitions for the tile load sequencer: FSM states, stream
// byte counts and the byte counter width.
package tile_load_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_K    = 3'd1,
    LOAD_A    = 3'd2,
    RUN       = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  localparam int KERNEL_BYTES = 9;
  localparam int TILE_BYTES   = 16;
  localparam int CNT_W        = 5;

  // Counter values at which the last byte of each section is accepted.
  localparam logic [CNT_W-1:0] KERNEL_LAST = CNT_W'(KERNEL_BYTES - 1);
  localparam logic [CNT_W-1:0] TILE_LAST   = CNT_W'(TILE_BYTES - 1);

endpackage

// File: rtl/tile_load_sequencer_byte_bank.sv
// loader_byte_bank: write-indexed register bank. Entry idx takes din when
// we is high; every entry is visible on the flat output, entry 0 in the
// least significant slice. Entries hold until overwritten or reset.
module loader_byte_bank
  import tile_load_sequencer_pkg::*;
#(
  parameter int DEPTH = 9,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [CNT_W-1:0]       idx,
  input  logic [WIDTH-1:0]       din,
  output logic [DEPTH*WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Select the addressed entry for update and flatten the bank for output.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (we && (idx == CNT_W'(i))) begin
        mem_d[i] = din;
      end
      dout[i*WIDTH +: WIDTH] = mem_q[i];
    end
  end

  // Bank storage, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/tile_load_sequencer.sv
// tile_load_sequencer: loads a 3x3 kernel and a 4x4 tile from a byte
// stream, runs the array until it reports done, then captures the 2x2
// result with a one-cycle valid pulse.
// Optional feature macro: TILE_LOADER_KERNEL_REUSE_EN (skip the kernel
// load when a kernel is already resident and load_kernel is low).
module tile_load_sequencer
  import tile_load_sequencer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_kernel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic [DATA_W-1:0] a11, a12, a13, a14,
  output logic [DATA_W-1:0] a21, a22, a23, a24,
  output logic [DATA_W-1:0] a31, a32, a33, a34,
  output logic [DATA_W-1:0] a41, a42, a43, a44,
  output logic [DATA_W-1:0] b11, b12, b13,
  output logic [DATA_W-1:0] b21, b22, b23,
  output logic [DATA_W-1:0] b31, b32, b33,
  output logic              active_single,
  input  logic              done_single,
  input  logic [DATA_W-1:0] c11, c12, c21, c22,
  output logic [DATA_W-1:0] r11, r12, r21, r22,
  output logic              res_valid
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              active_q, active_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] r11_q, r12_q, r21_q, r22_q;
  logic [DATA_W-1:0] r11_d, r12_d, r21_d, r22_d;
  logic              hs;
  logic              need_kernel;
  logic              kernel_we, tile_we;
  logic [KERNEL_BYTES*DATA_W-1:0] b_flat;
  logic [TILE_BYTES*DATA_W-1:0]   a_flat;

  assign hs = in_valid && in_ready_q;

`ifdef TILE_LOADER_KERNEL_REUSE_EN
  logic kernel_loaded_q, kernel_loaded_d;

  // A kernel is forced whenever none is resident yet.
  assign need_kernel     = load_kernel || !kernel_loaded_q;
  assign kernel_loaded_d = kernel_loaded_q ||
                           ((state_q == LOAD_K) && hs && (cnt_q == KERNEL_LAST));

  // Residency flag for the kernel bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kernel_loaded_q <= 1'b0;
    end else begin
      kernel_loaded_q <= kernel_loaded_d;
    end
  end
`else
  logic unused_load_kernel;

  assign need_kernel        = 1'b1;
  assign unused_load_kernel = load_kernel;
`endif

  // Next-state, byte counter and bank write enables.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kernel_we = 1'b0;
    tile_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = need_kernel ? LOAD_K : LOAD_A;
        end
      end
      LOAD_K: begin
        if (hs) begin
          kernel_we = 1'b1;
          if (cnt_q == KERNEL_LAST) begin
            cnt_d   = '0;
            state_d = LOAD_A;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      LOAD_A: begin
        if (hs) begin
          tile_we = 1'b1;
          if (cnt_q == TILE_LAST) begin
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RUN:       state_d = WAIT_DONE;
      WAIT_DONE: if (done_single) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Registered outputs decoded from the upcoming state, plus result capture.
  always_comb begin
    in_ready_d  = (state_d == LOAD_K) || (state_d == LOAD_A);
    busy_d      = (state_d != IDLE);
    active_d    = (state_d == RUN) || (state_d == WAIT_DONE);
    res_valid_d = 1'b0;
    r11_d       = r11_q;
    r12_d       = r12_q;
    r21_d       = r21_q;
    r22_d       = r22_q;
    if ((state_q == WAIT_DONE) && done_single) begin
      res_valid_d = 1'b1;
      r11_d       = c11;
      r12_d       = c12;
      r21_d       = c21;
      r22_d       = c22;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      active_q    <= 1'b0;
      res_valid_q <= 1'b0;
      r11_q       <= '0;
      r12_q       <= '0;
      r21_q       <= '0;
      r22_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      active_q    <= active_d;
      res_valid_q <= res_valid_d;
      r11_q       <= r11_d;
      r12_q       <= r12_d;
      r21_q       <= r21_d;
      r22_q       <= r22_d;
    end
  end

  loader_byte_bank #(.DEPTH(KERNEL_BYTES), .WIDTH(DATA_W)) u_kernel_bank (
    .clk  (clk),
    .rst  (rst),
    .we   (kernel_we),
    .idx  (cnt_q),
    .din  (in_data),
    .dout (b_flat)
  );

  loader_byte_bank #(.DEPTH(TILE_BYTES), .WIDTH(DATA_W)) u_tile_bank (
    .clk  (clk),
    .rst  (rst),
    .we   (tile_we),
    .idx  (cnt_q),
    .din  (in_data),
    .dout (a_flat)
  );

  assign in_ready      = in_ready_q;
  assign busy          = busy_q;
  assign active_single = active_q;
  assign res_valid     = res_valid_q;
  assign r11 = r11_q;
  assign r12 = r12_q;
  assign r21 = r21_q;
  assign r22 = r22_q;

  assign b11 = b_flat[0*DATA_W +: DATA_W];
  assign b12 = b_flat[1*DATA_W +: DATA_W];
  assign b13 = b_flat[2*DATA_W +: DATA_W];
  assign b21 = b_flat[3*DATA_W +: DATA_W];
  assign b22 = b_flat[4*DATA_W +: DATA_W];
  assign b23 = b_flat[5*DATA_W +: DATA_W];
  assign b31 = b_flat[6*DATA_W +: DATA_W];
  assign b32 = b_flat[7*DATA_W +: DATA_W];
  assign b33 = b_flat[8*DATA_W +: DATA_W];

  assign a11 = a_flat[0*DATA_W +: DATA_W];
  assign a12 = a_flat[1*DATA_W +: DATA_W];
  assign a13 = a_flat[2*DATA_W +: DATA_W];
  assign a14 = a_flat[3*DATA_W +: DATA_W];
  assign a21 = a_flat[4*DATA_W +: DATA_W];
  assign a22 = a_flat[5*DATA_W +: DATA_W];
  assign a23 = a_flat[6*DATA_W +: DATA_W];
  assign a24 = a_flat[7*DATA_W +: DATA_W];
  assign a31 = a_flat[8*DATA_W +: DATA_W];
  assign a32 = a_flat[9*DATA_W +: DATA_W];
  assign a33 = a_flat[10*DATA_W +: DATA_W];
  assign a34 = a_flat[11*DATA_W +: DATA_W];
  assign a41 = a_flat[12*DATA_W +: DATA_W];
  assign a42 = a_flat[13*DATA_W +: DATA_W];
  assign a43 = a_flat[14*DATA_W +: DATA_W];
  assign a44 = a_flat[15*DATA_W +: DATA_W];

endmodule

// File: tb/tb_tile_load_sequencer.sv
// Bench for tile_load_sequencer. Expected register contents come from the
// accepted byte stream split into kernel and tile sections; the kernel
// section exists when a kernel is required (always, unless
// TILE_LOADER_KERNEL_REUSE_EN is defined and a kernel is already resident).
module tb_tile_load_sequencer;

  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic load_kernel = 1'b0;
  logic in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic done_single = 1'b0;
  logic [DATA_W-1:0] c11 = '0, c12 = '0, c21 = '0, c22 = '0;

  logic in_ready, busy, active_single, res_valid;
  logic [DATA_W-1:0] a11, a12, a13, a14, a21, a22, a23, a24;
  logic [DATA_W-1:0] a31, a32, a33, a34, a41, a42, a43, a44;
  logic [DATA_W-1:0] b11, b12, b13, b21, b22, b23, b31, b32, b33;
  logic [DATA_W-1:0] r11, r12, r21, r22;

  always #5 clk = ~clk;

  tile_load_sequencer #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .load_kernel(load_kernel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .busy(busy),
    .a11(a11), .a12(a12), .a13(a13), .a14(a14),
    .a21(a21), .a22(a22), .a23(a23), .a24(a24),
    .a31(a31), .a32(a32), .a33(a33), .a34(a34),
    .a41(a41), .a42(a42), .a43(a43), .a44(a44),
    .b11(b11), .b12(b12), .b13(b13),
    .b21(b21), .b22(b22), .b23(b23),
    .b31(b31), .b32(b32), .b33(b33),
    .active_single(active_single), .done_single(done_single),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22),
    .r11(r11), .r12(r12), .r21(r21), .r22(r22),
    .res_valid(res_valid)
  );

  logic [DATA_W-1:0] dut_a [16];
  logic [DATA_W-1:0] dut_b [9];
  logic [DATA_W-1:0] dut_r [4];

  assign dut_a[0] = a11;  assign dut_a[1] = a12;  assign dut_a[2] = a13;  assign dut_a[3] = a14;
  assign dut_a[4] = a21;  assign dut_a[5] = a22;  assign dut_a[6] = a23;  assign dut_a[7] = a24;
  assign dut_a[8] = a31;  assign dut_a[9] = a32;  assign dut_a[10] = a33; assign dut_a[11] = a34;
  assign dut_a[12] = a41; assign dut_a[13] = a42; assign dut_a[14] = a43; assign dut_a[15] = a44;
  assign dut_b[0] = b11; assign dut_b[1] = b12; assign dut_b[2] = b13;
  assign dut_b[3] = b21; assign dut_b[4] = b22; assign dut_b[5] = b23;
  assign dut_b[6] = b31; assign dut_b[7] = b32; assign dut_b[8] = b33;
  assign dut_r[0] = r11; assign dut_r[1] = r12; assign dut_r[2] = r21; assign dut_r[3] = r22;

  int checks_total = 0;
  int checks_passed = 0;

  // Reference model state
  logic [DATA_W-1:0] stream [$];
  logic [DATA_W-1:0] exp_a [16];
  logic [DATA_W-1:0] exp_b [9];
  logic [DATA_W-1:0] exp_r [4];
  bit model_kl = 1'b0;

  function automatic bit need_kernel(input bit lk);
`ifdef TILE_LOADER_KERNEL_REUSE_EN
    return lk || !model_kl;
`else
    return 1'b1;
`endif
  endfunction

  // Split the stream into kernel and tile sections as the sequencer should.
  task automatic model_load(input bit need);
    int off;
    off = 0;
    if (need) begin
      for (int i = 0; i < 9; i++) exp_b[i] = stream[i];
      off = 9;
      model_kl = 1'b1;
    end
    for (int i = 0; i < 16; i++) exp_a[i] = stream[off + i];
  endtask

  task automatic model_reset();
    model_kl = 1'b0;
    for (int i = 0; i < 16; i++) exp_a[i] = '0;
    for (int i = 0; i < 9; i++) exp_b[i] = '0;
    for (int i = 0; i < 4; i++) exp_r[i] = '0;
  endtask

  task automatic fill_random(input int n);
    stream.delete();
    for (int i = 0; i < n; i++) stream.push_back(DATA_W'($urandom_range(0, 255)));
  endtask

  // Pulse start, then feed the stream until active_single rises (or
  // stop_after handshakes). gap_mode: 0 continuous, 1 pattern 1,0,0, 2 random.
  task automatic drive_load(input bit lk, input int gap_mode, input int stop_after,
                            input int glitch_at, output int hs, output bit rise_ok,
                            output bit timed_out);
    bit was_hs, will_hs, glitched;
    int n;
    start = 1'b1;
    load_kernel = lk;
    @(posedge clk); #1;
    start = 1'b0;
    load_kernel = 1'b0;
    hs = 0; rise_ok = 1'b0; timed_out = 1'b1; was_hs = 1'b0; glitched = 1'b0;
    for (n = 0; n < 400; n++) begin
      if (active_single) begin
        rise_ok = was_hs;
        timed_out = 1'b0;
        break;
      end
      if (stop_after != 0 && hs == stop_after) begin
        timed_out = 1'b0;
        break;
      end
      case (gap_mode)
        0: in_valid = 1'b1;
        1: in_valid = ((n % 3) == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = (hs < stream.size()) ? stream[hs] : '0;
      if (!glitched && glitch_at >= 0 && hs == glitch_at) begin
        start = 1'b1;
        load_kernel = 1'b1;
        glitched = 1'b1;
      end else begin
        start = 1'b0;
        load_kernel = 1'b0;
      end
      will_hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (will_hs) hs++;
      was_hs = will_hs;
    end
    in_valid = 1'b0;
    start = 1'b0;
    load_kernel = 1'b0;
  endtask

  // Play the array: after delay cycles raise done with the given results
  // and wait for res_valid.
  task automatic finish_run(input int delay, input logic [DATA_W-1:0] v0, input logic [DATA_W-1:0] v1,
                            input logic [DATA_W-1:0] v2, input logic [DATA_W-1:0] v3,
                            output bit timed_out);
    c11 = v0; c12 = v1; c21 = v2; c22 = v3;
    repeat (delay) begin @(posedge clk); #1; end
    done_single = 1'b1;
    timed_out = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (res_valid) begin
        timed_out = 1'b0;
        break;
      end
    end
    done_single = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks_total++;
    if ({in_ready, busy, active_single, res_valid} !== 4'b0000)
      $display("[TB] FAIL reset_ctrl: got %b expected 0000", {in_ready, busy, active_single, res_valid});
    else checks_passed++;
    for (int i = 0; i < 16; i++) begin
      checks_total++;
      if (dut_a[i] !== '0) $display("[TB] FAIL reset_a[%0d]: got %0d expected 0", i, dut_a[i]);
      else checks_passed++;
    end
    for (int i = 0; i < 9; i++) begin
      checks_total++;
      if (dut_b[i] !== '0) $display("[TB] FAIL reset_b[%0d]: got %0d expected 0", i, dut_b[i]);
      else checks_passed++;
    end
    for (int i = 0; i < 4; i++) begin
      checks_total++;
      if (dut_r[i] !== '0) $display("[TB] FAIL reset_r[%0d]: got %0d expected 0", i, dut_r[i]);
      else checks_passed++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_full_load();
    int hs;
    bit rise_ok, to;
    stream.delete();
    for (int i = 1; i <= 9; i++) stream.push_back(DATA_W'(i));
    for (int i = 1; i <= 16; i++) stream.push_back(DATA_W'(i));
    model_load(need_kernel(1'b1));
    drive_load(1'b1, 0, 0, -1, hs, rise_ok, to);
    checks_total++;
    if (to) $display("[TB] FAIL full_load_timeout: active_single never rose");
    else checks_passed++;
    checks_total++;
    if (hs !== 25) $display("[TB] FAIL full_load_handshakes: got %0d expected 25", hs);
    else checks_passed++;
    checks_total++;
    if (rise_ok !== 1'b1) $display("[TB] FAIL full_load_active_timing: got %0d expected 1", rise_ok);
    else checks_passed++;
    checks_total++;
    if ({busy, in_ready} !== 2'b10) $display("[TB] FAIL full_load_busy_ready: got %b expected 10", {busy, in_ready});
    else checks_passed++;
    for (int i = 0; i < 9; i++) begin
      checks_total++;
      if (dut_b[i] !== exp_b[i]) $display("[TB] FAIL full_load_b[%0d]: got %0d expected %0d", i, dut_b[i], exp_b[i]);
      else checks_passed++;
    end
    for (int i = 0; i < 16; i++) begin
      checks_total++;
      if (dut_a[i] !== exp_a[i]) $display("[TB] FAIL full_load_a[%0d]: got %0d expected %0d", i, dut_a[i], exp_a[i]);
      else checks_passed++;
    end
  endtask

  task automatic test_result_capture();
    bit to;
    exp_r[0] = 8'd192; exp_r[1] = 8'd237; exp_r[2] = 8'd116; exp_r[3] = 8'd161;
    finish_run(37, exp_r[0], exp_r[1], exp_r[2], exp_r[3], to);
    checks_total++;
    if (to) $display("[TB] FAIL capture_timeout: res_valid never rose");
    else checks_passed++;
    for (int i = 0; i < 4; i++) begin
      checks_total++;
      if (dut_r[i] !== exp_r[i]) $display("[TB] FAIL capture_r[%0d]: got %0d expected %0d", i, dut_r[i], exp_r[i]);
      else checks_passed++;
    end
    checks_total++;
    if ({active_single, busy} !== 2'b00) $display("[TB] FAIL capture_active_drop: got %b expected 00", {active_single, busy});
    else checks_passed++;
    c11 = 8'hAA; c12 = 8'hAA; c21 = 8'hAA; c22 = 8'hAA;
    @(posedge clk); #1;
    checks_total++;
    if (res_valid !== 1'b0) $display("[TB] FAIL capture_pulse_width: got %0d expected 0", res_valid);
    else checks_passed++;
    checks_total++;
    if (r11 !== exp_r[0]) $display("[TB] FAIL capture_hold: got %0d expected %0d", r11, exp_r[0]);
    else checks_passed++;
  endtask

  task automatic test_kernel_reuse();
    int hs, exp_hs;
    bit rise_ok, to, need;
    need = need_kernel(1'b0);
    exp_hs = need ? 25 : 16;
    stream.delete();
    if (need) for (int i = 0; i < 9; i++) stream.push_back(DATA_W'($urandom_range(0, 255)));
    for (int i = 16; i >= 1; i--) stream.push_back(DATA_W'(i));
    model_load(need);
    drive_load(1'b0, 2, 0, -1, hs, rise_ok, to);
    checks_total++;
    if (to || hs !== exp_hs) $display("[TB] FAIL reuse_handshakes: got %0d (timeout %0d) expected %0d", hs, to, exp_hs);
    else checks_passed++;
    checks_total++;
    if (a11 !== 8'd16) $display("[TB] FAIL reuse_a11: got %0d expected 16", a11);
    else checks_passed++;
    for (int i = 0; i < 9; i++) begin
      checks_total++;
      if (dut_b[i] !== exp_b[i]) $display("[TB] FAIL reuse_b[%0d]: got %0d expected %0d", i, dut_b[i], exp_b[i]);
      else checks_passed++;
    end
    for (int i = 0; i < 4; i++) exp_r[i] = DATA_W'($urandom_range(0, 255));
    finish_run($urandom_range(0, 10), exp_r[0], exp_r[1], exp_r[2], exp_r[3], to);
    checks_total++;
    if (to || {r11, r12, r21, r22} !== {exp_r[0], exp_r[1], exp_r[2], exp_r[3]})
      $display("[TB] FAIL reuse_result: got %h expected %h", {r11, r12, r21, r22}, {exp_r[0], exp_r[1], exp_r[2], exp_r[3]});
    else checks_passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int hs;
    bit rise_ok, to;
    fill_random(25);
    model_load(need_kernel(1'b1));
    drive_load(1'b1, 1, 0, 21, hs, rise_ok, to);
    checks_total++;
    if (to || hs !== 25) $display("[TB] FAIL gaps_handshakes: got %0d (timeout %0d) expected 25", hs, to);
    else checks_passed++;
    checks_total++;
    if (rise_ok !== 1'b1) $display("[TB] FAIL gaps_active_timing: got %0d expected 1", rise_ok);
    else checks_passed++;
    for (int i = 0; i < 9; i++) begin
      checks_total++;
      if (dut_b[i] !== exp_b[i]) $display("[TB] FAIL gaps_b[%0d]: got %0d expected %0d", i, dut_b[i], exp_b[i]);
      else checks_passed++;
    end
    for (int i = 0; i < 16; i++) begin
      checks_total++;
      if (dut_a[i] !== exp_a[i]) $display("[TB] FAIL gaps_a[%0d]: got %0d expected %0d", i, dut_a[i], exp_a[i]);
      else checks_passed++;
    end
    for (int i = 0; i < 4; i++) exp_r[i] = DATA_W'($urandom_range(0, 255));
    finish_run($urandom_range(0, 10), exp_r[0], exp_r[1], exp_r[2], exp_r[3], to);
    checks_total++;
    if (to || {r11, r12, r21, r22} !== {exp_r[0], exp_r[1], exp_r[2], exp_r[3]})
      $display("[TB] FAIL gaps_result: got %h expected %h", {r11, r12, r21, r22}, {exp_r[0], exp_r[1], exp_r[2], exp_r[3]});
    else checks_passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_stale_done();
    int hs, exp_hs;
    bit rise_ok, to, lk, need;
    lk = 1'($urandom_range(0, 1));
    need = need_kernel(lk);
    exp_hs = need ? 25 : 16;
    fill_random(exp_hs);
    model_load(need);
    for (int i = 0; i < 4; i++) exp_r[i] = DATA_W'($urandom_range(0, 255));
    c11 = exp_r[0]; c12 = exp_r[1]; c21 = exp_r[2]; c22 = exp_r[3];
    done_single = 1'b1;
    drive_load(lk, 2, 0, -1, hs, rise_ok, to);
    checks_total++;
    if (to || hs !== exp_hs) $display("[TB] FAIL stale_handshakes: got %0d (timeout %0d) expected %0d", hs, to, exp_hs);
    else checks_passed++;
    checks_total++;
    if ({active_single, res_valid} !== 2'b10) $display("[TB] FAIL stale_enter_run: got %b expected 10", {active_single, res_valid});
    else checks_passed++;
    @(posedge clk); #1;
    checks_total++;
    if ({active_single, res_valid} !== 2'b10) $display("[TB] FAIL stale_run_masked: got %b expected 10", {active_single, res_valid});
    else checks_passed++;
    @(posedge clk); #1;
    checks_total++;
    if ({active_single, res_valid} !== 2'b01) $display("[TB] FAIL stale_capture: got %b expected 01", {active_single, res_valid});
    else checks_passed++;
    checks_total++;
    if ({r11, r12, r21, r22} !== {exp_r[0], exp_r[1], exp_r[2], exp_r[3]})
      $display("[TB] FAIL stale_result: got %h expected %h", {r11, r12, r21, r22}, {exp_r[0], exp_r[1], exp_r[2], exp_r[3]});
    else checks_passed++;
    @(posedge clk); #1;
    checks_total++;
    if ({busy, res_valid} !== 2'b00) $display("[TB] FAIL stale_done_in_idle: got %b expected 00", {busy, res_valid});
    else checks_passed++;
    done_single = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    int hs;
    bit rise_ok, to;
    fill_random(25);
    drive_load(1'b1, 0, 12, -1, hs, rise_ok, to);
    checks_total++;
    if (to || hs !== 12) $display("[TB] FAIL midrst_partial: got %0d expected 12", hs);
    else checks_passed++;
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks_total++;
    if ({in_ready, busy, active_single, res_valid} !== 4'b0000)
      $display("[TB] FAIL midrst_ctrl: got %b expected 0000", {in_ready, busy, active_single, res_valid});
    else checks_passed++;
    for (int i = 0; i < 9; i++) begin
      checks_total++;
      if (dut_b[i] !== '0) $display("[TB] FAIL midrst_b[%0d]: got %0d expected 0", i, dut_b[i]);
      else checks_passed++;
    end
    for (int i = 0; i < 16; i++) begin
      checks_total++;
      if (dut_a[i] !== '0) $display("[TB] FAIL midrst_a[%0d]: got %0d expected 0", i, dut_a[i]);
      else checks_passed++;
    end
    for (int i = 0; i < 4; i++) begin
      checks_total++;
      if (dut_r[i] !== '0) $display("[TB] FAIL midrst_r[%0d]: got %0d expected 0", i, dut_r[i]);
      else checks_passed++;
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    fill_random(25);
    model_load(need_kernel(1'b0));
    drive_load(1'b0, 2, 0, -1, hs, rise_ok, to);
    checks_total++;
    if (to || hs !== 25) $display("[TB] FAIL midrst_kernel_forced: got %0d (timeout %0d) expected 25", hs, to);
    else checks_passed++;
    for (int i = 0; i < 9; i++) begin
      checks_total++;
      if (dut_b[i] !== exp_b[i]) $display("[TB] FAIL midrst_reload_b[%0d]: got %0d expected %0d", i, dut_b[i], exp_b[i]);
      else checks_passed++;
    end
    for (int i = 0; i < 16; i++) begin
      checks_total++;
      if (dut_a[i] !== exp_a[i]) $display("[TB] FAIL midrst_reload_a[%0d]: got %0d expected %0d", i, dut_a[i], exp_a[i]);
      else checks_passed++;
    end
    finish_run(2, 8'd1, 8'd2, 8'd3, 8'd4, to);
    checks_total++;
    if (to || {r11, r12, r21, r22} !== {8'd1, 8'd2, 8'd3, 8'd4})
      $display("[TB] FAIL midrst_result: got %h expected 01020304", {r11, r12, r21, r22});
    else checks_passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_result_capture();
    test_kernel_reuse();
    test_backpressure();
    test_stale_done();
    test_kernel_reuse();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
